rr_stream_mux: RTL
==================

// Module: rr_stream_mux
// PURPOSE
//  N-channel registered stream multiplexer with valid/ready handshake on every port.
//  It arbitrates among channels with pending data: round-robin or fixed priority.
//  Packets can optionally be held on one channel until their last beat.
//  Forwards the granted beat, plus its channel index, through a single output register.
//  Parametrised, sequential successor to the 2-bit select mux/encoder.
//  Sits between several producers and one shared downstream consumer.
// PARAMETERS
//  NUM_CH    4  number of input channels, >=2
//  DATA_W    8  payload width per channel
//  ARB_MODE  0  0 = round-robin, 1 = fixed priority (lowest index wins)
//  LOCK_PKT  1  1 = hold grant on a channel until its in_last beat is accepted
//  SEL_W     derived localparam, clog2(NUM_CH) (min 1), not overridable
// PORTS
//  clk       in   1               single clock, rising edge
//  rst       in   1               synchronous, active-high reset
//  in_valid  in   NUM_CH          per-channel beat valid
//  in_ready  out  NUM_CH          per-channel beat accepted this cycle
//  in_data   in   NUM_CH*DATA_W   flattened payloads; ch i = [i*DATA_W +: DATA_W]
//  in_last   in   NUM_CH          per-channel end-of-packet marker
//  out_valid out  1               output register holds a beat
//  out_ready in   1               downstream accepts beat
//  out_data  out  DATA_W          forwarded payload
//  out_last  out  1               forwarded in_last
//  out_sel   out  SEL_W           index of the channel that supplied the beat
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_last=0, out_sel=0.
//    Reset also clears rr pointer=0, lock=0, lock_ch=0. in_ready=0 while rst=1.
//  - Reset mid-packet or mid-stall drops the held beat and the lock, with no partial-state carry.
//  - slot_free = ~out_valid | out_ready. Pass-through rate is 1 beat/cycle.
//  - Grant (combinational, one-hot over in_valid):
//    - lock=1: grant only lock_ch.
//    - RR: first valid channel at or after ptr, searching upward with wrap.
//    - FIXED: lowest valid index.
//  - in_ready[i] = grant[i] & slot_free & ~rst. Never more than one bit high.
//  - accept = |(in_valid & in_ready). On accept, at the next edge:
//    out_data/out_last/out_sel <= granted channel's data/last/index, and out_valid <= 1.
//  - No accept and out_ready=1: out_valid <= 0.
//    out_data, out_last and out_sel keep their last value.
//  - out_valid=1 & out_ready=0: all out_* held stable. No input is accepted.
//  - Latency: input beat to out_valid is 1 cycle.
//  - Pointer (RR only): on accept with lock not continuing, ptr <= (g+1) mod NUM_CH.
//    Wrap is from NUM_CH-1 to 0. Pointer is otherwise unchanged.
//  - Lock (LOCK_PKT=1):
//    - accept with in_last=0: lock <= 1, lock_ch <= g.
//    - accept with in_last=1: lock <= 0.
//    - Under lock, other channels' in_ready=0 even if the locked channel has in_valid=0.
//    - LOCK_PKT=0: every beat is arbitrated independently, and in_last is only forwarded.
//  - in_valid may be deasserted before acceptance. There is no sticky requirement on producers.
// STRUCTURE
//  - Shared header mux_defs.vh holds:
//    - ARB_RR=0 and ARB_FIXED=1 codes
//    - clog2 constant function, reused by other parametrised muxes
//  - Sub-module rr_arbiter (NUM_CH, ARB_MODE) owns:
//    - request -> one-hot grant plus grant index
//    - rotating pointer, advanced by an 'advance' strobe
//  - Top level owns the lock FSM (IDLE/LOCKED), the output register, and the payload select.
// TESTING  (NUM_CH=4, DATA_W=8)
//  1 rst=1 2 cycles, then in_valid=4'b1111, out_ready=1 (RR), in_data ch i = 8'hA0+i, in_last=1:
//    -> out_sel 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
//  2 Stream on ch2 only, out_ready=0 for 3 cycles after the first beat:
//    -> out_data held at that beat, in_ready=0 during the stall.
//    -> After release, one beat per cycle, none lost or duplicated.
//  3 LOCK_PKT=1: ch1 sends 3 beats (11,12,13; last on 13), ch2 valid throughout:
//    -> out_sel=1 for 3 beats, then 2. in_ready[2]=0 until 13 is accepted.
//  4 ARB_MODE=1, ch0 and ch3 valid for 5 cycles, out_ready=1:
//    -> out_sel=0 every cycle, in_ready[3]=0 throughout.
//  5 rst=1 asserted mid-packet (lock held, out_valid=1):
//    -> next cycle out_valid=0, out_sel=0, lock cleared.
//    -> First grant after reset is ch0 when all channels are valid.
//  6 in_valid=0 everywhere for 3 cycles after a beat, out_ready=1:
//    -> out_valid drops after 1 cycle. out_data keeps its last value.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// rtl/rr_stream_mux_pkg.sv - shared arbitration codes, lock states and width helper for stream muxes
//
// Purpose: arbitration-mode codes, the lock FSM state type and a clog2-style
// width function reused by the parametrised stream multiplexers.
// Ports: none (package).

package rr_stream_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rtl/rr_stream_mux_arbiter.sv - one-hot request arbiter with rotating round-robin pointer
//
// Purpose: turns a request vector into a one-hot grant plus its index.
// Round-robin mode searches upward from a rotating pointer with wrap; fixed
// mode picks the lowest requesting index.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer -> 0)
//   req        per-channel request
//   advance    move the pointer to one past the current grant
//   grant      one-hot grant (zero when no request)
//   grant_idx  index of the granted channel
//   grant_any  some channel is granted

module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_any
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = SEL_W'(k);
            end else begin
                idx = SEL_W'((int'(ptr) + k) % NUM_CH);
            end
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel registered stream mux with round-robin/fixed arbitration
//
// Purpose: arbitrates among valid input channels, optionally holds the grant
// on one channel until its last beat, and forwards the granted beat with its
// channel index through a single output register (1 beat/cycle throughput).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   per-channel beat valid
//   in_ready   per-channel beat accepted this cycle (at most one bit high)
//   in_data    flattened payloads, channel i at [i*DATA_W +: DATA_W]
//   in_last    per-channel end-of-packet marker
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
//   out_data   forwarded payload
//   out_last   forwarded end-of-packet marker
//   out_sel    index of the channel that supplied the beat

module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_W   = 8,
    parameter  int ARB_MODE = ARB_RR,
    parameter  int LOCK_PKT = 1,
    localparam int SEL_W    = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_sel
);

    localparam bit LOCK_EN = (LOCK_PKT != 0);

    lock_state_t       state, state_next;
    logic [SEL_W-1:0]  lock_ch, lock_ch_next;
    logic [NUM_CH-1:0] lock_mask;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic              slot_free;
    logic              accept;
    logic              advance;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    // While locked only the locked channel may request, so other channels
    // stay stalled even when the locked producer idles mid-packet.
    always_comb begin
        lock_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lock_mask[i] = (SEL_W'(i) == lock_ch);
        end
    end

    assign req       = (state == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = rst ? '0 : (grant & {NUM_CH{slot_free}});
    assign accept    = grant_any & slot_free & ~rst;
    // The pointer only moves once a packet is finished, so a locked packet
    // does not rotate priority away from where it started.
    assign advance   = accept & (sel_last | ~LOCK_EN);

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // One-hot AND-OR payload select.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
                sel_last = sel_last | in_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_next;
            lock_ch <= lock_ch_next;
        end
    end

    always_comb begin
        state_next   = state;
        lock_ch_next = lock_ch;
        if (LOCK_EN && accept) begin
            if (sel_last) begin
                state_next = ST_IDLE;
            end else begin
                state_next   = ST_LOCKED;
                lock_ch_next = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
